// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the ID-stage branch logic.
// Holds the branch-type encoding, the ARM condition-code values and the
// bit positions of N, Z, C and V inside the 4-bit flag vector.
package cpu_pkg;

  typedef enum logic [2:0] {
    BR_NONE  = 3'd0,
    BR_B     = 3'd1,
    BR_BCOND = 3'd2,
    BR_CBZ   = 3'd3,
    BR_CBNZ  = 3'd4,
    BR_BR    = 3'd5
  } br_type_e;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_HS = 4'b0010;
  localparam logic [3:0] COND_LO = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition-code evaluator.
// Ports:
//   cond  [3:0] in  condition field of a B.cond
//   flags [3:0] in  {N,Z,C,V} to test against
//   pass        out condition holds
module cond_eval
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n;
  logic z;
  logic c;
  logic v;
  logic gt;

  assign n  = flags[FLAG_N];
  assign z  = flags[FLAG_Z];
  assign c  = flags[FLAG_C];
  assign v  = flags[FLAG_V];
  assign gt = ~z & (n == v);

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_HS: pass = c;
      COND_LO: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~(c & ~z);
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = gt;
      COND_LE: pass = ~gt;
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/flag_branch_unit.sv
// ID-stage branch resolution with NZCV flag register and EX flag forwarding.
// Resolves B/BR/B.cond/CBZ/CBNZ in the same cycle they sit in ID, stalls
// CBZ/CBNZ while the forwarded Rt is not yet available, and counts
// resolved-taken and resolved-not-taken branches.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   ex_valid, ex_set_flags     EX holds a flag-setting instruction
//   ex_neg/ex_carry/ex_ovf     ALU N, C, V of EX result
//   ex_res_nz                  OR-reduction of EX result (Z = ~ex_res_nz)
//   id_valid, id_br_type       ID instruction and its branch class
//   id_cond                    condition field for B.cond
//   id_reg_nz, id_reg_ok       OR-reduction of forwarded Rt and its validity
//   br_taken, br_stall         resolution outputs back to IF/ID
//   flags_q                    architectural {N,Z,C,V}
//   cnt_taken, cnt_not_taken   wrapping branch event counters
module flag_branch_unit
  import cpu_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic             ex_set_flags,
  input  logic             ex_neg,
  input  logic             ex_carry,
  input  logic             ex_ovf,
  input  logic             ex_res_nz,
  input  logic             id_valid,
  input  logic [2:0]       id_br_type,
  input  logic [3:0]       id_cond,
  input  logic             id_reg_nz,
  input  logic             id_reg_ok,
  output logic             br_taken,
  output logic             br_stall,
  output logic [3:0]       flags_q,
  output logic [CNT_W-1:0] cnt_taken,
  output logic [CNT_W-1:0] cnt_not_taken
);

  br_type_e   br_type_p0;
  logic       flag_wr_p0;
  logic [3:0] flags_ex_p0;
  logic [3:0] flags_eff_p0;
  logic       cond_pass_p0;
  logic       is_cb_p0;
  logic       taken_raw_p0;
  logic       vld_p0;

  // ID stage: decode, forwarding mux and zero-cycle resolution
  assign br_type_p0   = (id_br_type > 3'd5) ? BR_NONE : br_type_e'(id_br_type);
  assign flag_wr_p0   = ex_valid & ex_set_flags;
  assign flags_ex_p0  = {ex_neg, ~ex_res_nz, ex_carry, ex_ovf};
  assign flags_eff_p0 = flag_wr_p0 ? flags_ex_p0 : flags_q;

  cond_eval u_cond_eval (
    .cond  (id_cond),
    .flags (flags_eff_p0),
    .pass  (cond_pass_p0)
  );

  assign is_cb_p0 = (br_type_p0 == BR_CBZ) | (br_type_p0 == BR_CBNZ);

  always_comb begin
    taken_raw_p0 = 1'b0;
    case (br_type_p0)
      BR_B, BR_BR: taken_raw_p0 = 1'b1;
      BR_BCOND:    taken_raw_p0 = cond_pass_p0;
      BR_CBZ:      taken_raw_p0 = ~id_reg_nz;
      BR_CBNZ:     taken_raw_p0 = id_reg_nz;
      default:     taken_raw_p0 = 1'b0;
    endcase
  end

  // Reset masks both outputs so a stall pending at reset is simply dropped.
  assign br_stall = ~reset & id_valid & is_cb_p0 & ~id_reg_ok;
  assign vld_p0   = ~reset & id_valid & (br_type_p0 != BR_NONE) & ~br_stall;
  assign br_taken = vld_p0 & taken_raw_p0;

  // Registered state: flag register and event counters
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= 4'b0000;
    end else if (flag_wr_p0) begin
      flags_q <= flags_ex_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_taken     <= '0;
      cnt_not_taken <= '0;
    end else if (vld_p0) begin
      if (taken_raw_p0) begin
        cnt_taken <= cnt_taken + CNT_W'(1);
      end else begin
        cnt_not_taken <= cnt_not_taken + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/flag_branch_unit.md
# flag_branch_unit

Consumes the 64-bit OR-reduction zero-detect results and resolves conditional branches in the ID stage of the 5-stage pipelined CPU. Holds the architectural NZCV flag register written by flag-setting EX-stage instructions, and forwards same-cycle EX flags to a B.cond in ID with no bubble. Resolves CBZ/CBNZ from the OR-reduction of the forwarded register operand. Drives branch-taken and stall back to IF/ID, and keeps taken/not-taken event counters for performance debug.

## Interface
- CNT_W, 32, width of each branch event counter
- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  synchronous, active-high
- ex_valid  in  1  EX holds a real instruction, not a bubble
- ex_set_flags  in  1  EX instruction writes NZCV (ADDS/SUBS class)
- ex_neg, ex_carry, ex_ovf  in  1 each  ALU N, C, V of EX result
- ex_res_nz  in  1  OR-reduction of 64-bit EX ALU result; Z = ~ex_res_nz
- id_valid  in  1  ID holds a real instruction
- id_br_type  in  3  NONE=0, B=1, BCOND=2, CBZ=3, CBNZ=4, BR=5; 6-7 treated as NONE
- id_cond  in  4  ARM condition field for BCOND
- id_reg_nz  in  1  OR-reduction of forwarded Rt value for CBZ/CBNZ
- id_reg_ok  in  1  forwarded Rt is valid (low on load-use hazard)
- br_taken  out  1  ID branch resolves taken this cycle
- br_stall  out  1  ID must hold; EX receives a bubble
- flags_q  out  4  architectural {N,Z,C,V}
- cnt_taken  out  CNT_W  resolved-taken count
- cnt_not_taken  out  CNT_W  resolved-not-taken count

## Operation
- Effective flags: flags_eff = {ex_neg, ~ex_res_nz, ex_carry, ex_ovf} when ex_valid & ex_set_flags; otherwise flags_q.
- Flag write: when ex_valid & ex_set_flags, flags_q <= {ex_neg, ~ex_res_nz, ex_carry, ex_ovf} at the next edge. Otherwise flags_q holds.
- Condition evaluation on flags_eff:
  - EQ Z, NE !Z, HS C, LO !C, MI N, PL !N, VS V, VC !V
  - HI C&!Z, LS !(C&!Z), GE N==V, LT N!=V, GT !Z&(N==V), LE !GT
  - 1110 and 1111 are always true.
- Resolution, only when id_valid:
  - B, BR: taken.
  - BCOND: taken = cond(flags_eff).
  - CBZ: taken = ~id_reg_nz.
  - CBNZ: taken = id_reg_nz.
  - NONE: br_taken=0.
- Stall: br_stall = id_valid & (type CBZ or CBNZ) & ~id_reg_ok. While stalled, br_taken=0.
- Resolution event: id_valid & type≠NONE & ~br_stall. Increments cnt_taken or cnt_not_taken, never both. Counters wrap modulo 2^CNT_W.
- A branch held in ID by br_stall is counted once, in the cycle it resolves.
- Pipeline contract: when br_stall is asserted, upstream logic bubbles EX (ex_valid=0) the next cycle. The block does not guard against a re-executed flag-setter.
- Simultaneous case: EX flag-setter with BCOND in ID uses the EX flags, and flags_q updates on the same edge.

## Timing
- br_taken, br_stall: combinational from inputs and flags_q, valid within the same cycle. Zero-cycle resolution in ID.
- flags_q, counters: registered, 1-cycle latency from EX/ID event.
- Reset (sync): flags_q=4'b0000, cnt_taken=0, cnt_not_taken=0.
- While reset is high, br_taken=0 and br_stall=0 regardless of inputs.
- Reset asserted mid-stall drops the stall the same cycle, and the pending branch is not counted.

## Structure
- Shared package cpu_pkg holds:
  - br_type_e enum (3-bit)
  - condition-code localparams COND_EQ..COND_AL
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
- One sub-module, cond_eval: combinational (cond[3:0], flags[3:0]) -> pass.
- flag_branch_unit contains the flag register, forwarding mux, resolution/stall logic and the two counters.

## Test plan
- Reset then idle: flags_q=0000, counters 0. BCOND EQ with no EX setter gives br_taken=0 (Z=0).
- SUBS in EX with ex_res_nz=0, ex_carry=1, BCOND EQ in the same cycle: br_taken=1 via forwarding. Next cycle flags_q=0110, cnt_taken=1.
- flags_q=1000 (N=1,V=0), BCOND LT then GE on consecutive cycles: taken then not taken. cnt_taken=1, cnt_not_taken=1.
- CBZ with id_reg_ok=0 for 2 cycles, then id_reg_ok=1, id_reg_nz=0:
  - br_stall=1 for 2 cycles, then br_taken=1.
  - cnt_taken increments exactly once.
- Sweep all 16 id_cond values against all 16 flag patterns: br_taken matches the condition equations. 1110 and 1111 are always taken.
- Preload cnt_taken to 2^CNT_W−1, then resolve one taken B: cnt_taken wraps to 0. Reset asserted during a CBZ stall gives br_stall=0 that cycle and counters 0 next cycle.
